// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, port and width constants for the memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way winner select, round-robin or fixed A priority on ties.
module rr_arb2 import mem_arb_pkg::*; #(
  parameter int FIXED_PRIO = 0
) (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic win
);
  always_comb win = (req_a && req_b) ? ((FIXED_PRIO != 0) ? PORT_A : ~last) : (req_a ? PORT_A : PORT_B);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters onto one synchronous memory port with registered commands.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int FIXED_PRIO = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_in,
  input  logic [DATA_W-1:0] mem_dout
);
  logic [1:0] state;
  logic owner, last, win, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (.req_a(a_req), .req_b(b_req), .last(last), .win(win));
  assign sel_we = win ? b_we : a_we;
  assign sel_addr = win ? b_addr : a_addr;
  assign sel_wdata = win ? b_wdata : a_wdata;
  // MemRead doubles as the read/write flag while in CMD
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      owner <= PORT_A;
      last <= PORT_B;
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      MemRead <= 1'b0;
      MemWrite <= 1'b0;
      ADDR <= '0;
      Data_in <= '0;
    end else begin
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        IDLE: if (a_req || b_req) begin
          owner <= win;
          last <= win;
          a_gnt <= (win == PORT_A);
          b_gnt <= (win == PORT_B);
          MemWrite <= sel_we;
          MemRead <= ~sel_we;
          ADDR <= sel_addr;
          Data_in <= sel_wdata;
          state <= CMD;
        end
        CMD: begin
          MemRead <= 1'b0;
          MemWrite <= 1'b0;
          state <= MemRead ? RDWAIT : IDLE;
        end
        RDWAIT: begin
          if (owner == PORT_A) begin
            a_rdata <= mem_dout;
            a_rvalid <= 1'b1;
          end else begin
            b_rdata <= mem_dout;
            b_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural 256x8 synchronous memory.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [7:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, mem_read, mem_write;
  logic [7:0] a_rdata, b_rdata, addr, data_in, dout;
  logic [7:0] mem [256];
  logic f_a_req = 0, f_b_req = 0;
  logic f_a_gnt, f_b_gnt, f_a_rvalid, f_b_rvalid, f_mr, f_mw;
  logic [7:0] f_a_rdata, f_b_rdata, f_addr, f_din;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.FIXED_PRIO(0)) dut (
    .CLK(clk), .RST(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .MemRead(mem_read), .MemWrite(mem_write), .ADDR(addr), .Data_in(data_in),
    .mem_dout(dout)
  );
  mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .CLK(clk), .RST(rst),
    .a_req(f_a_req), .a_we(1'b1), .a_addr(8'h30), .a_wdata(8'hAA),
    .b_req(f_b_req), .b_we(1'b1), .b_addr(8'h31), .b_wdata(8'hBB),
    .a_gnt(f_a_gnt), .b_gnt(f_b_gnt), .a_rvalid(f_a_rvalid), .b_rvalid(f_b_rvalid),
    .a_rdata(f_a_rdata), .b_rdata(f_b_rdata),
    .MemRead(f_mr), .MemWrite(f_mw), .ADDR(f_addr), .Data_in(f_din),
    .mem_dout(8'h00)
  );
  always @(posedge clk) begin
    if (mem_write) mem[addr] <= data_in;
    if (mem_read) dout <= mem[addr];
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_cmd", {mem_read, mem_write}, 0);
    chk("rst_addr_din", {addr, data_in}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    rst = 0;
    // fixed priority: A monopolises ties, B only after A drops
    f_a_req = 1;
    f_b_req = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fp_gnt", {f_a_gnt, f_b_gnt}, 2'b10);
      chk("fp_mw", f_mw, 1);
      if (k == 2) f_a_req = 0;
      step();
      chk("fp_idle_gnt", {f_a_gnt, f_b_gnt}, 2'b00);
    end
    step();
    chk("fp_b_gnt", {f_a_gnt, f_b_gnt}, 2'b01);
    chk("fp_b_addr", f_addr, 8'h31);
    f_b_req = 0;
    step();
    // single write then read on A
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h3C;
    step();
    chk("w_a_gnt", {a_gnt, b_gnt}, 2'b10);
    chk("w_cmd", {mem_read, mem_write}, 2'b01);
    chk("w_addr_din", {addr, data_in}, 16'h103C);
    a_req = 0;
    step();
    chk("w_done", {mem_write, a_gnt}, 0);
    chk("w_mem", mem[8'h10], 8'h3C);
    a_req = 1; a_we = 0; a_addr = 8'h10;
    step();
    chk("r_a_gnt", a_gnt, 1);
    chk("r_cmd", {mem_read, mem_write}, 2'b10);
    a_req = 0;
    step();
    chk("r_wait_rvalid", {a_rvalid, mem_read}, 0);
    step();
    chk("r_rvalid", {a_rvalid, b_rvalid}, 2'b10);
    chk("r_rdata", a_rdata, 8'h3C);
    // back-to-back writes on B, data = address
    b_req = 1; b_we = 1; b_addr = 0; b_wdata = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("bb_gnt", {a_gnt, b_gnt, mem_write}, 3'b011);
      chk("bb_addr_din", {addr, data_in}, {i[7:0], i[7:0]});
      if (i == 15) b_req = 0;
      else begin b_addr = 8'(i + 1); b_wdata = 8'(i + 1); end
      step();
      chk("bb_gap", {b_gnt, mem_write}, 0);
    end
    b_req = 1; b_we = 0; b_addr = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("rb_gnt", b_gnt, 1);
      if (i == 15) b_req = 0;
      else b_addr = 8'(i + 1);
      step();
      step();
      chk("rb_rvalid", {a_rvalid, b_rvalid}, 2'b01);
      chk("rb_rdata", b_rdata, i[7:0]);
    end
    // round-robin tie: last grant was B, so A goes first
    a_req = 1; a_we = 0; a_addr = 8'h01;
    b_req = 1; b_we = 0; b_addr = 8'h02;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_gnt", {a_gnt, b_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k == 3) begin a_req = 0; b_req = 0; end
      step();
      chk("rr_wait", {a_gnt, b_gnt, a_rvalid, b_rvalid}, 0);
      step();
      chk("rr_rvalid", {a_rvalid, b_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_rdata", (k % 2 == 0) ? a_rdata : b_rdata, (k % 2 == 0) ? 8'h01 : 8'h02);
    end
    // reset in RDWAIT swallows the read and restores the pointer to B
    a_req = 1; a_we = 0; a_addr = 8'h05;
    step();
    chk("mr_gnt", a_gnt, 1);
    a_req = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    chk("mr_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("mr_rdata", {a_rdata, b_rdata}, 0);
    chk("mr_cmd_addr", {mem_read, mem_write, addr, data_in}, 0);
    a_req = 1; a_we = 0; a_addr = 8'h03;
    b_req = 1; b_we = 0; b_addr = 8'h04;
    step();
    chk("mr_tie_gnt", {a_gnt, b_gnt}, 2'b10);
    a_req = 0; b_req = 0;
    step();
    step();
    chk("mr_after_read", {a_rvalid, a_rdata}, {1'b1, 8'h03});
    // reset in CMD of a write: memory still takes the write
    a_req = 1; a_we = 1; a_addr = 8'h20; a_wdata = 8'h55;
    step();
    chk("rc_cmd", {a_gnt, mem_write}, 2'b11);
    a_req = 0;
    rst = 1;
    step();
    rst = 0;
    chk("rc_mem", mem[8'h20], 8'h55);
    chk("rc_outputs", {a_gnt, mem_write, mem_read, addr}, 0);
    a_req = 1; a_we = 0; a_addr = 8'h20;
    step();
    chk("rc_idle_gnt", {a_gnt, mem_read}, 2'b11);
    a_req = 0;
    step();
    step();
    chk("rc_readback", {a_rvalid, a_rdata}, {1'b1, 8'h55});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the 256×8 synchronous `memory` block. It lets two requesters share the single memory port:

- **Port A**: SimProc datapath.
- **Port B**: loader/debug interface.

It serialises their read and write requests, drives the memory's `MemRead`/`MemWrite`/`ADDR`/`Data_in` from registers, and returns each read result to the requester that issued it. It sits between the requesters and one `memory` instance. The memory itself is not inside this block.

## Interface
Parameters:
- `FIXED_PRIO`, default 0. 0 selects round-robin on ties; 1 means port A always wins ties.

Ports:
- `CLK` in 1: single clock; all state updates on posedge.
- `RST` in 1: synchronous, active-high reset.
- `a_req`, `b_req` in 1: request; sampled only while the FSM is in IDLE.
- `a_we`, `b_we` in 1: 1 = write, 0 = read; qualified by req.
- `a_addr`, `b_addr` in 8: byte address.
- `a_wdata`, `b_wdata` in 8: write data; ignored for reads.
- `a_gnt`, `b_gnt` out 1: one-cycle pulse meaning "request latched at the preceding edge".
- `a_rvalid`, `b_rvalid` out 1: one-cycle pulse; the matching rdata is valid this cycle.
- `a_rdata`, `b_rdata` out 8: last read data returned to that port; holds until the next read for that port.
- `MemRead`, `MemWrite` out 1: memory command, registered.
- `ADDR`, `Data_in` out 8: memory address and write data, registered.
- `mem_dout` in 8: memory `Data_out`.

## Operation
- **FSM states:** IDLE, CMD, RDWAIT.
- **IDLE:**
  - With no request, stay in IDLE.
  - With any request, pick a winner. At the edge:
    - Latch the winner's we/addr/wdata into `MemWrite`/`MemRead`/`ADDR`/`Data_in`.
    - Set the winner's gnt.
    - Record the winner as owner and as last-granted.
    - Go to CMD.
- **CMD:**
  - The memory command is presented for exactly this cycle and the gnt pulse is high.
  - At the edge, `MemRead` and `MemWrite` clear to 0. `ADDR` and `Data_in` hold.
  - For a write, go to IDLE.
  - For a read, go to RDWAIT.
- **RDWAIT:**
  - `mem_dout` is valid this cycle.
  - At the edge, capture it into the owner's rdata, pulse the owner's rvalid, and go to IDLE.
- **Arbitration on ties (both req in IDLE):**
  - With FIXED_PRIO=0, the port not granted last wins.
  - The last-granted pointer resets to B, so A wins the first tie.
  - A single requester always wins, whatever the pointer says.
- **Handshake:**
  - A requester holds req/we/addr/wdata stable until it sees its gnt.
  - It may change or drop them in the gnt cycle.
  - req is not sampled in CMD or RDWAIT. A req still high on return to IDLE is a new request.
- **Mutual exclusion:** at most one of `MemRead`/`MemWrite` is ever high, and they are high only in CMD. At most one gnt and at most one rvalid are high per cycle.
- **Reset values:**
  - State = IDLE.
  - All gnt, rvalid, `MemRead` and `MemWrite` = 0.
  - `ADDR`, `Data_in`, `a_rdata` and `b_rdata` = 0.
  - Last-granted pointer = B.
- **Reset mid-operation:**
  - If `RST` is high in CMD, the memory still samples the command at that edge, so a write completes. The arbiter returns to IDLE with all outputs at reset values.
  - A read interrupted in CMD or RDWAIT never produces rvalid.

## Timing
- **Write:** req in cycle 0; gnt and `MemWrite` in cycle 1; memory updated at the end of cycle 1. The next request can be sampled in cycle 2, giving 1 write per 2 cycles.
- **Read:** req in cycle 0; gnt and `MemRead` in cycle 1; `mem_dout` valid in cycle 2; rvalid and rdata in cycle 3. IDLE is re-entered in cycle 3 and a new req can be sampled there, giving 1 read per 3 cycles.
- **Latency:** gnt always follows the sampled req by exactly 1 cycle.
- **Critical path:** no combinational path from any req input to any output.

## Structure
- **Package `mem_arb_pkg`:**
  - State encoding constants: IDLE, CMD, RDWAIT.
  - Port index constants: PORT_A=0, PORT_B=1.
  - Width constants: ADDR_W=8, DATA_W=8.
- **Sub-module `rr_arb2`:**
  - Combinational two-way winner select from req_a, req_b, the last-granted pointer and FIXED_PRIO.
  - It is instantiated once.
  - The pointer register lives in `mem_arbiter` and updates on the IDLE→CMD edge.

## Test plan
- **Single write then read on A:** A writes 0x3C to 0x10, then reads 0x10.
  - `a_gnt` is high in cycle 1 of each request.
  - `MemWrite` is high for 1 cycle with `ADDR`=0x10 and `Data_in`=0x3C.
  - `a_rvalid` pulses 3 cycles after the read req, with `a_rdata`=0x3C. `b_rvalid` stays 0.
- **Round-robin tie:** A and B both request reads continuously, at 0x01 and 0x02 respectively.
  - Grants are A, B, A, B…, spaced 3 cycles apart.
  - Each rvalid returns the correct location's data to the correct port only.
- **Fixed priority:** with FIXED_PRIO=1 and both requesting continuously, only A is granted. When A drops req, B is granted in the next IDLE cycle.
- **Back-to-back writes:** B writes 0x00 through 0x0F with data equal to the address.
  - `b_gnt` pulses every 2 cycles.
  - A subsequent readback of all 16 locations matches.
- **Reset mid-read:** assert `RST` in the RDWAIT cycle.
  - No rvalid is produced.
  - All outputs are at reset values in the next cycle.
  - A tie issued afterwards is granted to A.
- **Reset during CMD of a write:** A writes 0x55 to 0x20 and `RST` is asserted in CMD.
  - The memory still holds 0x55 at 0x20.
  - After reset, the arbiter is in IDLE with `MemWrite`=0.
